// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS control FSM.
//   state_t   - 4-bit FSM state codes (also exported on the debug port)
//   aluop_t   - ALU operation class handed from the FSM to the ALU decoder
//   ctrl_t    - bundle of raw per-state control outputs before reset gating
//   OP_*/FN_* - opcode / funct encodings; ALU_* - alucontrol encodings
//   op_legal  - opcode legality check (bne legality is parameter dependent)
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       memreq;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    aluop_t     aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op, input logic bne_en);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      OP_BNE:                                        ok = bne_en;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: combinational ALU decoder.
//   aluop      in  2  operation class from the FSM
//   funct      in  6  instr[5:0], only consulted for R-type (aluop 10)
//   alucontrol out 3  ALU operation select
// Unknown funct codes and the reserved aluop fall back to add.
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore control FSM for a shared-memory multicycle MIPS datapath.
//   clk, reset      clock (rising) / async active-high reset to FETCH
//   op, funct       opcode and funct fields from the instruction register
//   zero            ALU zero flag (branch resolution in BEQ)
//   memready        memory completes the current access this cycle
//   memreq..pcsrc   datapath mux selects and write enables
//   pcen            PC enable (jump/fetch writes, taken branches)
//   illegal         one-cycle pulse in DECODE for an unsupported opcode
//   state           current state, debug only
// BNE_EN=1 folds bne into the BEQ state with the zero flag inverted.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit BNE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  state_t cur, nxt;
  ctrl_t  c;
  logic   legal;
  logic   bne_inv;

  assign legal   = op_legal(op, BNE_EN);
  assign bne_inv = BNE_EN && (op == OP_BNE);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!legal) nxt = S_FETCH;
        else begin
          case (op)
            OP_LW, OP_SW:   nxt = S_MEMADR;
            OP_RTYPE:       nxt = S_EXECUTE;
            OP_BEQ, OP_BNE: nxt = S_BEQ;
            OP_ADDI:        nxt = S_ADDIEX;
            OP_J:           nxt = S_JUMP;
            default:        nxt = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = memready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   nxt = S_FETCH;
      S_MEMWR:   nxt = memready ? S_FETCH : S_MEMWR;
      S_EXECUTE: nxt = S_ALUWB;
      S_ALUWB:   nxt = S_FETCH;
      S_BEQ:     nxt = S_FETCH;
      S_ADDIEX:  nxt = S_ADDIWB;
      S_ADDIWB:  nxt = S_FETCH;
      S_JUMP:    nxt = S_FETCH;
      default:   nxt = S_FETCH;
    endcase
  end

  // output decode; FETCH's IR/PC writes follow memready so a stalled fetch
  // does not advance the PC
  always_comb begin
    c = '0;
    case (cur)
      S_FETCH: begin
        c.memreq  = 1'b1;
        c.alusrcb = 2'b01;
        c.irwrite = memready;
        c.pcwrite = memready;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.memreq = 1'b1;
        c.iord   = 1'b1;
      end
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.memreq   = 1'b1;
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQ: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (c.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // strobes are killed while reset is held so nothing fires before release
  assign memreq   = c.memreq   & ~reset;
  assign memwrite = c.memwrite & ~reset;
  assign irwrite  = c.irwrite  & ~reset;
  assign regwrite = c.regwrite & ~reset;
  assign pcen     = ~reset & (c.pcwrite | (c.branch & (zero ^ bne_inv)));

  assign iord     = c.iord;
  assign regdst   = c.regdst;
  assign memtoreg = c.memtoreg;
  assign alusrca  = c.alusrca;
  assign alusrcb  = c.alusrcb;
  assign pcsrc    = c.pcsrc;
  assign illegal  = (cur == S_DECODE) && !legal;
  assign state    = cur;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed-vector bench for mc_controller (BNE_EN=1).
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int nchk  = 0;
  int nfail = 0;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
                         BEQ = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11;

  always #5 clk = ~clk;

  mc_controller #(.BNE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .memreq(memreq), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
    .pcen(pcen), .illegal(illegal), .state(state)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH -> DECODE with the given instruction
  task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f);
    op = o; funct = f; memready = 1'b1;
    #1 chk("fetch_state", 8'(state), 8'(FETCH));
    tick();
    chk("decode_state", 8'(state), 8'(DECODE));
  endtask

  logic [5:0] fn_tab [6];
  logic [2:0] ac_tab [6];
  int         wcnt;

  initial begin
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    ac_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; memready = 1'b1;

    // reset held: FETCH values with strobes forced off
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",    8'(state), 8'(FETCH));
    chk("rst_memreq",   8'(memreq), 8'd0);
    chk("rst_irwrite",  8'(irwrite), 8'd0);
    chk("rst_pcen",     8'(pcen), 8'd0);
    chk("rst_alusrcb",  8'(alusrcb), 8'b01);
    reset = 1'b0;
    #1;
    chk("rel_memreq",   8'(memreq), 8'd1);
    chk("rel_irwrite",  8'(irwrite), 8'd1);
    chk("rel_pcen",     8'(pcen), 8'd1);

    // lw: 5 cycles
    fetch_decode(6'b100011, 6'd0);
    chk("lw_dec_alusrcb", 8'(alusrcb), 8'b11);
    tick(); chk("lw_memadr", 8'(state), 8'(MEMADR));
    chk("lw_adr_srcab", 8'({alusrca, alusrcb}), 8'b110);
    tick(); chk("lw_memrd", 8'(state), 8'(MEMRD));
    chk("lw_rd_req_iord", 8'({memreq, iord, memwrite}), 8'b110);
    tick(); chk("lw_memwb", 8'(state), 8'(MEMWB));
    chk("lw_wb_ctl", 8'({regwrite, memtoreg, regdst}), 8'b110);
    tick(); chk("lw_done", 8'(state), 8'(FETCH));

    // sw with 3 wait cycles in MEMWR
    fetch_decode(6'b101011, 6'd0);
    tick(); chk("sw_memadr", 8'(state), 8'(MEMADR));
    tick(); chk("sw_memwr", 8'(state), 8'(MEMWR));
    wcnt = 0;
    for (int i = 0; i < 4; i++) begin
      memready = (i == 3);
      #1;
      if (memwrite) wcnt++;
      chk("sw_pcen", 8'(pcen), 8'd0);
      tick();
    end
    chk("sw_memwrite_cycles", 8'(wcnt), 8'd4);
    chk("sw_done", 8'(state), 8'(FETCH));

    // R-type slt, plus funct table in EXECUTE
    fetch_decode(6'b000000, 6'b101010);
    tick(); chk("r_execute", 8'(state), 8'(EXECUTE));
    chk("r_slt", 8'(alucontrol), 8'b111);
    chk("r_srcab", 8'({alusrca, alusrcb}), 8'b100);
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      #1 chk($sformatf("r_funct_%0d", i), 8'(alucontrol), 8'(ac_tab[i]));
    end
    funct = 6'b101010;
    tick(); chk("r_aluwb", 8'(state), 8'(ALUWB));
    chk("r_wb_ctl", 8'({regwrite, regdst, memtoreg}), 8'b110);
    tick(); chk("r_done", 8'(state), 8'(FETCH));

    // beq: taken / not taken
    fetch_decode(6'b000100, 6'd0);
    tick(); chk("beq_state", 8'(state), 8'(BEQ));
    zero = 1'b1;
    #1 chk("beq_z1_pcen", 8'(pcen), 8'd1);
    chk("beq_pcsrc", 8'(pcsrc), 8'b01);
    chk("beq_aluctl", 8'(alucontrol), 8'b110);
    zero = 1'b0;
    #1 chk("beq_z0_pcen", 8'(pcen), 8'd0);
    tick(); chk("beq_done", 8'(state), 8'(FETCH));

    // bne: zero flag sense inverted
    fetch_decode(6'b000101, 6'd0);
    tick(); chk("bne_state", 8'(state), 8'(BEQ));
    zero = 1'b1;
    #1 chk("bne_z1_pcen", 8'(pcen), 8'd0);
    zero = 1'b0;
    #1 chk("bne_z0_pcen", 8'(pcen), 8'd1);
    tick(); chk("bne_done", 8'(state), 8'(FETCH));

    // addi
    fetch_decode(6'b001000, 6'd0);
    tick(); chk("addi_ex", 8'(state), 8'(ADDIEX));
    chk("addi_ex_ctl", 8'({alusrca, alusrcb, alucontrol}), 8'b110_010);
    tick(); chk("addi_wb", 8'(state), 8'(ADDIWB));
    chk("addi_wb_ctl", 8'({regwrite, regdst, memtoreg}), 8'b100);
    tick(); chk("addi_done", 8'(state), 8'(FETCH));

    // j
    fetch_decode(6'b000010, 6'd0);
    tick(); chk("j_state", 8'(state), 8'(JUMP));
    chk("j_ctl", 8'({pcen, pcsrc}), 8'b110);
    tick(); chk("j_done", 8'(state), 8'(FETCH));

    // illegal opcode
    fetch_decode(6'b111111, 6'd0);
    chk("ill_pulse", 8'(illegal), 8'd1);
    chk("ill_strobes", 8'({regwrite, memwrite, pcen, irwrite}), 8'd0);
    tick(); chk("ill_next", 8'(state), 8'(FETCH));
    chk("ill_clear", 8'(illegal), 8'd0);

    // stalled fetch holds state, no IR/PC write
    memready = 1'b0;
    #1 chk("stall_ctl", 8'({memreq, irwrite, pcen}), 8'b100);
    tick(); chk("stall_state", 8'(state), 8'(FETCH));

    // async reset in the middle of MEMRD
    fetch_decode(6'b100011, 6'd0);
    tick(); tick();
    memready = 1'b0;
    #1 chk("mid_memrd", 8'(state), 8'(MEMRD));
    reset = 1'b1;
    #1 chk("mid_rst_state", 8'(state), 8'(FETCH));
    chk("mid_rst_en", 8'({memreq, memwrite, irwrite, regwrite, pcen}), 8'd0);
    memready = 1'b1;
    tick();
    chk("mid_rst_hold", 8'(state), 8'(FETCH));
    chk("mid_rst_en2", 8'({memreq, irwrite, regwrite, pcen}), 8'd0);
    reset = 1'b0;
    #1 chk("mid_rel_fetch", 8'({memreq, irwrite, regwrite}), 8'b110);
    tick(); chk("mid_rel_decode", 8'(state), 8'(DECODE));

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
